// File: rtl/mac_dot_sequencer.sv
// Sequencer for the 8x8 signed MAC: buffers an operand vector, clears the MAC, streams
// the pairs without gaps, waits out the MAC pipeline and returns the 16-bit dot product.
module mac_dot_sequencer #(
    parameter int unsigned LEN     = 8,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_last,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    output logic        mac_clr,
    input  logic [15:0] mac_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_z,
    output logic [4:0]  out_len,
    output logic        busy
);

    localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {StLoad, StClear, StStream, StDrain, StHold} state_e;

    state_e          state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [IW-1:0]   idx_q, idx_d, idx_nxt;
    logic [DW-1:0]   drain_q, drain_d;
    logic [7:0]      mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [15:0]     out_z_q, out_z_d;
    logic [4:0]      out_len_q, out_len_d;
    logic            out_valid_q, out_valid_d;
    logic            accept;

    logic [7:0]      buf_a [2**IW];
    logic [7:0]      buf_b [2**IW];

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q != StLoad);
    assign mac_clr   = reset | (state_q == StClear);
    assign accept    = in_valid & in_ready;
    assign idx_nxt   = idx_q + IW'(1);
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign out_z     = out_z_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        mac_a_d     = '0;
        mac_b_d     = '0;
        out_z_d     = out_z_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    count_d = count_q + 5'd1;
                    if (in_last || (count_q + 5'd1 == 5'(LEN))) begin
                        state_d   = StClear;
                        out_len_d = count_q + 5'd1;
                    end
                end
            end
            StClear: begin
                // Operand registers are loaded one cycle ahead so STREAM has no bubbles.
                state_d = StStream;
                idx_d   = '0;
                mac_a_d = buf_a[0];
                mac_b_d = buf_b[0];
            end
            StStream: begin
                if (5'(idx_q) == out_len_q - 5'd1) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    idx_d   = idx_nxt;
                    mac_a_d = buf_a[idx_nxt];
                    mac_b_d = buf_b[idx_nxt];
                end
            end
            StDrain: begin
                if (drain_q == DW'(MAC_LAT - 1)) begin
                    out_z_d     = mac_z;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLoad;
            count_q     <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            out_z_q     <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            out_z_q     <= out_z_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_a[count_q[IW-1:0]] <= in_a;
            buf_b[count_q[IW-1:0]] <= in_b;
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomised self-checking bench for mac_dot_sequencer with a behavioural MAC and a
// plain-arithmetic dot-product reference.
module tb_mac_dot_sequencer;

    localparam int LEN     = 8;
    localparam int MAC_LAT = 2;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_last, mac_clr;
    logic        out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b, mac_a, mac_b;
    logic [15:0] mac_z, out_z;
    logic [4:0]  out_len;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] va [16];
    logic [7:0] vb [16];

    always #5 clk = ~clk;

    mac_dot_sequencer #(.LEN(LEN), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_clr   (mac_clr),
        .mac_z     (mac_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_len   (out_len),
        .busy      (busy)
    );

    // MAC environment: product register then accumulator, two cycles to mac_z.
    logic signed [15:0] mac_p, mac_acc;
    always_ff @(posedge clk) begin
        if (mac_clr) begin
            mac_p   <= '0;
            mac_acc <= '0;
        end else begin
            mac_p   <= $signed(mac_a) * $signed(mac_b);
            mac_acc <= mac_acc + mac_p;
        end
    end
    assign mac_z = mac_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_dot(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'($signed(va[i])) * int'($signed(vb[i]));
        return s[15:0];
    endfunction

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit last,
                             input bit gaps);
        int guard = 0;
        bit rdy;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                in_a = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        forever begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            guard++;
            if (guard > 50) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
    endtask

    task automatic run_vector(input int n, input bit use_last, input bit gaps, input int hold,
                              input bit early);
        int          cnt;
        bit          ok;
        logic [15:0] exp_z;
        exp_z     = ref_dot(n);
        out_ready = early;
        for (int i = 0; i < n; i++) send_pair(va[i], vb[i], use_last && (i == n - 1), gaps);
        // Now in the cycle after the final accept: the single CLEAR cycle.
        check("clr_pulse", mac_clr, 1);
        check("in_ready_low", in_ready, 0);
        check("mac_a_clear", mac_a, 0);
        ok = 1'b1;
        for (int j = 1; j <= n; j++) begin
            @(posedge clk); #1;
            check("stream_a", mac_a, va[j-1]);
            check("stream_b", mac_b, vb[j-1]);
            if (mac_clr !== 1'b0) ok = 1'b0;
        end
        check("clr_once", ok, 1);
        cnt = n;
        while (!out_valid && cnt < n + 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", cnt, n + 1 + MAC_LAT);
        check("out_z", out_z, exp_z);
        check("out_len", out_len, n);
        if (hold > 0) begin
            ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || out_z !== exp_z || in_ready !== 1'b0) ok = 1'b0;
            end
            check("hold_stable", ok, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("busy_low", busy, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mac_clr", mac_clr, 1);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_out_len", out_len, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_b", mac_b, 0);
        check("rst_busy", busy, 0);
        check("rst_mac_clr", mac_clr, 0);

        // Forced end at LEN pairs, squares 1..8.
        for (int i = 0; i < 8; i++) begin
            va[i] = 8'(i + 1);
            vb[i] = 8'(i + 1);
        end
        run_vector(8, 1'b0, 1'b0, 0, 1'b0);

        // Single pair, out_ready raised before out_valid.
        va[0] = 8'h80;
        vb[0] = 8'h80;
        run_vector(1, 1'b1, 1'b0, 0, 1'b1);

        // Wraparound, no saturation.
        for (int i = 0; i < 8; i++) begin
            va[i] = 8'd127;
            vb[i] = 8'd127;
        end
        run_vector(8, 1'b1, 1'b0, 0, 1'b0);

        // Short vector with consumer back-pressure.
        va[0] = 8'd3;  vb[0] = 8'hFC;
        va[1] = 8'hFB; vb[1] = 8'd6;
        va[2] = 8'd7;  vb[2] = 8'd7;
        run_vector(3, 1'b1, 1'b0, 5, 1'b0);

        // Abort during STREAM at idx=4.
        for (int i = 0; i < 8; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
        end
        for (int i = 0; i < 8; i++) send_pair(va[i], vb[i], 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("abort_idx4", mac_a, va[4]);
        reset = 1'b1;
        #1;
        check("abort_mac_clr", mac_clr, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        check("abort_no_result", ok, 1);
        va[0] = 8'd2;
        vb[0] = 8'd2;
        run_vector(1, 1'b1, 1'b0, 0, 1'b0);

        // Random vectors with producer gaps.
        repeat (3) begin
            for (int i = 0; i < 8; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
            run_vector(8, 1'b0, 1'b1, 0, 1'b0);
        end
        repeat (2) begin
            int n;
            n = int'($urandom_range(LEN, 1));
            for (int i = 0; i < n; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
            run_vector(n, 1'b1, 1'b1, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
